// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-serial memory arbiter: FSM states, access
// sizes, requester IDs and the IO port addresses gated by io_buffer_full.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_t;

    localparam logic [31:0] IO_PORT_A_DEF = 32'h0003_0000;
    localparam logic [31:0] IO_PORT_B_DEF = 32'h0003_0004;

    // The illegal size code 3 is treated as a word access.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_to_nbytes = 3'd1;
            SZ_HALF: size_to_nbytes = 3'd2;
            default: size_to_nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes plus the byte-serial RAM/IO bus owned by mem_arbiter.
// master = requesters and memory (environment side), slave = the arbiter.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport master (
        output if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
               mem_din, io_buffer_full,
        input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
               mem_din, io_buffer_full,
        output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_byte_assembler.sv
// Collects read bytes arriving one cycle after their address and places them
// little-endian; 'word' already includes the byte currently on din.
module mem_byte_assembler
    import mem_arbiter_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        start,
    input  logic        capture,
    input  logic [2:0]  nbytes,
    input  logic [7:0]  din,
    output logic        last,
    output logic [31:0] word
);

    logic [2:0]  rcv_cnt_r;
    logic [31:0] data_r;
    logic [31:0] placed_s;

    // Drop the incoming byte into the lane selected by the received count
    always_comb begin
        placed_s = data_r;
        case (rcv_cnt_r[1:0])
            2'd0:    placed_s[7:0]   = din;
            2'd1:    placed_s[15:8]  = din;
            2'd2:    placed_s[23:16] = din;
            default: placed_s[31:24] = din;
        endcase
    end

    assign word = placed_s;
    assign last = capture && (rcv_cnt_r == (nbytes - 3'd1));

    // Received-byte counter and partial word; cleared on every grant
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rcv_cnt_r <= 3'd0;
            data_r    <= 32'd0;
        end else if (rdy_in) begin
            if (start) begin
                rcv_cnt_r <= 3'd0;
                data_r    <= 32'd0;
            end else if (capture) begin
                rcv_cnt_r <= rcv_cnt_r + 3'd1;
                data_r    <= placed_s;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the byte-serial RAM/IO bus shared by instruction fetch and the
// load/store buffer. Define MEM_ARB_ROUND_ROBIN_EN for round-robin on ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] IO_PORT_A = IO_PORT_A_DEF,
    parameter logic [31:0] IO_PORT_B = IO_PORT_B_DEF
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         clear,
    mem_arbiter_if.slave bus
);

    state_t      state_r,    state_nxt_s;
    req_id_t     owner_r,    owner_nxt_s;
    logic [31:0] mem_a_r,    mem_a_nxt_s;
    logic [7:0]  mem_dout_r, mem_dout_nxt_s;
    logic        mem_wr_r,   mem_wr_nxt_s;
    logic [31:0] wdata_r,    wdata_nxt_s;
    logic [2:0]  nbytes_r,   nbytes_nxt_s;
    logic [2:0]  iss_r,      iss_nxt_s;
    logic        din_valid_r, din_valid_nxt_s;
    logic        if_done_r,  if_done_nxt_s;
    logic        ls_done_r,  ls_done_nxt_s;
    logic [31:0] if_data_r,  if_data_nxt_s;
    logic [31:0] ls_rdata_r, ls_rdata_nxt_s;

    logic        ls_io_s;
    logic        ls_ok_s;
    logic        pick_ls_s;
    logic        asm_start_s;
    logic        asm_capture_s;
    logic        asm_last_s;
    logic [31:0] asm_word_s;

    assign ls_io_s = (bus.ls_addr == IO_PORT_A) || (bus.ls_addr == IO_PORT_B);
    assign ls_ok_s = bus.ls_req && !(bus.io_buffer_full && ls_io_s);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_t last_r;

    // Remember the last winner; only real grants count, so blocked IO does not
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_r <= REQ_IF;
        end else if (rdy_in && (state_r == ST_IDLE) && (state_nxt_s != ST_IDLE)) begin
            last_r <= owner_nxt_s;
        end
    end

    assign pick_ls_s = ls_ok_s && (!bus.if_req || (last_r == REQ_IF));
`else
    assign pick_ls_s = ls_ok_s;
`endif

    assign asm_capture_s = (state_r == ST_READ) && din_valid_r;

    mem_byte_assembler u_asm (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rdy_in  (rdy_in),
        .start   (asm_start_s),
        .capture (asm_capture_s),
        .nbytes  (nbytes_r),
        .din     (bus.mem_din),
        .last    (asm_last_s),
        .word    (asm_word_s)
    );

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_nxt_s     = state_r;
        owner_nxt_s     = owner_r;
        mem_a_nxt_s     = mem_a_r;
        mem_dout_nxt_s  = mem_dout_r;
        mem_wr_nxt_s    = 1'b0;
        wdata_nxt_s     = wdata_r;
        nbytes_nxt_s    = nbytes_r;
        iss_nxt_s       = iss_r;
        din_valid_nxt_s = 1'b0;
        if_done_nxt_s   = 1'b0;
        ls_done_nxt_s   = 1'b0;
        if_data_nxt_s   = if_data_r;
        ls_rdata_nxt_s  = ls_rdata_r;
        asm_start_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear) begin
                    state_nxt_s = ST_IDLE;
                end else if (pick_ls_s) begin
                    owner_nxt_s  = REQ_LS;
                    mem_a_nxt_s  = bus.ls_addr;
                    nbytes_nxt_s = size_to_nbytes(bus.ls_size);
                    iss_nxt_s    = 3'd1;
                    asm_start_s  = 1'b1;
                    if (bus.ls_wr) begin
                        state_nxt_s    = ST_WRITE;
                        mem_wr_nxt_s   = 1'b1;
                        mem_dout_nxt_s = bus.ls_wdata[7:0];
                        wdata_nxt_s    = bus.ls_wdata >> 4'd8;
                    end else begin
                        state_nxt_s = ST_READ;
                    end
                end else if (bus.if_req) begin
                    owner_nxt_s  = REQ_IF;
                    mem_a_nxt_s  = bus.if_addr;
                    nbytes_nxt_s = 3'd4;
                    iss_nxt_s    = 3'd1;
                    asm_start_s  = 1'b1;
                    state_nxt_s  = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                // the first READ cycle is the bubble: mem_din not yet valid
                din_valid_nxt_s = 1'b1;
                if (clear) begin
                    state_nxt_s = ST_IDLE;
                end else if (asm_last_s) begin
                    state_nxt_s = ST_IDLE;
                    if (owner_r == REQ_IF) begin
                        if_done_nxt_s = 1'b1;
                        if_data_nxt_s = asm_word_s;
                    end else begin
                        ls_done_nxt_s  = 1'b1;
                        ls_rdata_nxt_s = asm_word_s;
                    end
                end else if (iss_r < nbytes_r) begin
                    mem_a_nxt_s = mem_a_r + 32'd1;
                    iss_nxt_s   = iss_r + 3'd1;
                end else begin
                    iss_nxt_s = iss_r;
                end
            end
            ST_WRITE: begin
                // stores always finish, clear is ignored here
                if (iss_r < nbytes_r) begin
                    mem_wr_nxt_s   = 1'b1;
                    mem_a_nxt_s    = mem_a_r + 32'd1;
                    mem_dout_nxt_s = wdata_r[7:0];
                    wdata_nxt_s    = wdata_r >> 4'd8;
                    iss_nxt_s      = iss_r + 3'd1;
                end else begin
                    state_nxt_s   = ST_IDLE;
                    ls_done_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; rdy_in low freezes everything
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r     <= ST_IDLE;
            owner_r     <= REQ_IF;
            mem_a_r     <= 32'd0;
            mem_dout_r  <= 8'd0;
            mem_wr_r    <= 1'b0;
            wdata_r     <= 32'd0;
            nbytes_r    <= 3'd1;
            iss_r       <= 3'd0;
            din_valid_r <= 1'b0;
            if_done_r   <= 1'b0;
            ls_done_r   <= 1'b0;
            if_data_r   <= 32'd0;
            ls_rdata_r  <= 32'd0;
        end else if (rdy_in) begin
            state_r     <= state_nxt_s;
            owner_r     <= owner_nxt_s;
            mem_a_r     <= mem_a_nxt_s;
            mem_dout_r  <= mem_dout_nxt_s;
            mem_wr_r    <= mem_wr_nxt_s;
            wdata_r     <= wdata_nxt_s;
            nbytes_r    <= nbytes_nxt_s;
            iss_r       <= iss_nxt_s;
            din_valid_r <= din_valid_nxt_s;
            if_done_r   <= if_done_nxt_s;
            ls_done_r   <= ls_done_nxt_s;
            if_data_r   <= if_data_nxt_s;
            ls_rdata_r  <= ls_rdata_nxt_s;
        end
    end

    assign bus.mem_a    = mem_a_r;
    assign bus.mem_dout = mem_dout_r;
    assign bus.mem_wr   = mem_wr_r;
    assign bus.if_done  = if_done_r;
    assign bus.if_data  = if_data_r;
    assign bus.ls_done  = ls_done_r;
    assign bus.ls_rdata = ls_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a RAM model serves the bus, expected
// read data and write bytes are queued at request time and popped on output.
`timescale 1ns/1ps
module tb_mem_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic clear;
    logic ram_load;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clear  (clear),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0]  ram [0:4095];
    logic [31:0] if_exp [$];
    logic [32:0] ls_exp [$];
    wr_t         wr_exp [$];
    wr_t         mon_w;
    logic [32:0] mon_ls;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] addr, input int n);
        logic [31:0] w;
        logic [31:0] a;
        w = 32'd0;
        for (int k = 0; k < n; k++) begin
            a = addr + k;
            w[8*k +: 8] = ram[a[11:0]];
        end
        return w;
    endfunction

    // RAM model: read data one cycle after the address, writes on mem_wr
    always @(posedge clk_in) begin
        bus.mem_din <= ram[bus.mem_a[11:0]];
        if (ram_load) begin
            for (int i = 0; i < 4096; i++) ram[i] = 8'(i) ^ 8'h5A;
            ram[12'h100] = 8'h11;
            ram[12'h101] = 8'h22;
            ram[12'h102] = 8'h33;
            ram[12'h103] = 8'h44;
        end else if (bus.mem_wr) begin
            ram[bus.mem_a[11:0]] = bus.mem_dout;
        end
    end

    // Output monitor: pop and compare on every done pulse and write cycle
    always @(negedge clk_in) begin
        if (bus.if_done) begin
            if (if_exp.size() == 0) check("if_spurious_done", {31'd0, bus.if_done}, 32'd0);
            else check("if_data", bus.if_data, if_exp.pop_front());
        end
        if (bus.ls_done) begin
            if (ls_exp.size() == 0) check("ls_spurious_done", {31'd0, bus.ls_done}, 32'd0);
            else begin
                mon_ls = ls_exp.pop_front();
                if (mon_ls[32]) check("ls_rdata", bus.ls_rdata, mon_ls[31:0]);
            end
        end
        if (bus.mem_wr && rdy_in) begin
            if (wr_exp.size() == 0) check("spurious_wr", {31'd0, bus.mem_wr}, 32'd0);
            else begin
                mon_w = wr_exp.pop_front();
                check("wr_addr", bus.mem_a, mon_w.addr);
                check("wr_data", {24'd0, bus.mem_dout}, {24'd0, mon_w.data});
            end
        end
    end

    task automatic access(input logic is_if, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic chk_a, input string tag);
        int n;
        int lat;
        logic done;
        n = is_if ? 4 : ((size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4);
        if (is_if) begin
            if_exp.push_back(ram_word(addr, 4));
            bus.if_addr = addr;
            bus.if_req  = 1'b1;
        end else begin
            if (wr) begin
                for (int k = 0; k < n; k++) wr_exp.push_back('{addr + k, wdata[8*k +: 8]});
                ls_exp.push_back({1'b0, 32'd0});
            end else begin
                ls_exp.push_back({1'b1, ram_word(addr, n)});
            end
            bus.ls_wr    = wr;
            bus.ls_size  = size;
            bus.ls_addr  = addr;
            bus.ls_wdata = wdata;
            bus.ls_req   = 1'b1;
        end
        lat  = -1;
        done = 1'b0;
        while (!done && lat < 60) begin
            @(negedge clk_in);
            lat++;
            if (chk_a && lat < n) check({tag, "_addr"}, bus.mem_a, addr + lat);
            done = is_if ? bus.if_done : bus.ls_done;
        end
        if (is_if) bus.if_req = 1'b0;
        else bus.ls_req = 1'b0;
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        clear  = 1'b0;
        ram_load = 1'b1;
        bus.if_req = 1'b0;
        bus.if_addr = 32'd0;
        bus.ls_req = 1'b0;
        bus.ls_wr = 1'b0;
        bus.ls_size = 2'd0;
        bus.ls_addr = 32'd0;
        bus.ls_wdata = 32'd0;
        bus.io_buffer_full = 1'b0;
        repeat (3) @(negedge clk_in);
        ram_load = 1'b0;
        rst_in   = 1'b0;
        check("rst_mem_wr", bus.mem_wr, 32'd0);
        check("rst_mem_a", bus.mem_a, 32'd0);
        check("rst_mem_dout", bus.mem_dout, 32'd0);
        check("rst_if_done", bus.if_done, 32'd0);
        check("rst_ls_done", bus.ls_done, 32'd0);
        check("rst_if_data", bus.if_data, 32'd0);
        check("rst_ls_rdata", bus.ls_rdata, 32'd0);

        // basic transfers, back-to-back, sizes, wrap
        access(1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'd0, 5, 1'b1, "if_rd");
        access(1'b0, 1'b1, 2'd2, 32'h0000_0200, 32'hAABB_CCDD, 4, 1'b1, "sw");
        access(1'b0, 1'b0, 2'd2, 32'h0000_0200, 32'd0, 5, 1'b1, "lw");
        access(1'b0, 1'b0, 2'd1, 32'h0000_0202, 32'd0, 3, 1'b1, "lh");
        access(1'b0, 1'b0, 2'd0, 32'h0000_0203, 32'd0, 2, 1'b1, "lb");
        access(1'b0, 1'b0, 2'd3, 32'h0000_0100, 32'd0, 5, 1'b1, "lsz3");
        access(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_5A6B, 2, 1'b1, "sh_wrap");
        access(1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'd0, 3, 1'b1, "lh_wrap");

        // contention: LSB first, IF granted on the ls_done cycle
        fork
            access(1'b0, 1'b0, 2'd0, 32'h0000_0040, 32'd0, 2, 1'b1, "cont_ls");
            access(1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'd0, 8, 1'b0, "cont_if");
        join

        // rdy_in low for three cycles stretches the read
        fork
            access(1'b1, 1'b0, 2'd2, 32'h0000_0104, 32'd0, 8, 1'b0, "rdy_if");
            begin
                @(negedge clk_in);
                rdy_in = 1'b0;
                repeat (3) @(negedge clk_in);
                rdy_in = 1'b1;
            end
        join

        // IO gate: blocked store lets IF through, then writes once
        bus.io_buffer_full = 1'b1;
        fork
            access(1'b0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0077, 7, 1'b0, "io_sb");
            access(1'b1, 1'b0, 2'd2, 32'h0000_0108, 32'd0, 5, 1'b1, "io_if");
            begin
                repeat (6) begin
                    @(negedge clk_in);
                    check("io_blk_wr", bus.mem_wr, 32'd0);
                end
                bus.io_buffer_full = 1'b0;
            end
        join

        // clear mid IF read: no if_done, IDLE right after
        bus.if_addr = 32'h0000_0100;
        bus.if_req  = 1'b1;
        repeat (2) @(negedge clk_in);
        clear = 1'b1;
        bus.if_req = 1'b0;
        @(negedge clk_in);
        clear = 1'b0;
        check("clr_no_done", bus.if_done, 32'd0);
        access(1'b0, 1'b0, 2'd0, 32'h0000_0041, 32'd0, 2, 1'b1, "clr_ls");

        // clear with both requests pending suppresses that cycle's grant
        clear = 1'b1;
        fork
            access(1'b0, 1'b0, 2'd0, 32'h0000_0042, 32'd0, 3, 1'b0, "clrb_ls");
            access(1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'd0, 9, 1'b0, "clrb_if");
            begin
                @(negedge clk_in);
                clear = 1'b0;
            end
        join

        // clear during the second byte of a half store: store completes
        fork
            access(1'b0, 1'b1, 2'd1, 32'h0000_0300, 32'h0000_1234, 2, 1'b1, "clr_sh");
            begin
                repeat (2) @(negedge clk_in);
                clear = 1'b1;
                @(negedge clk_in);
                clear = 1'b0;
            end
        join
        access(1'b0, 1'b0, 2'd1, 32'h0000_0300, 32'd0, 3, 1'b1, "clr_lh");

        // reset mid-store: two bytes go out, then the bus goes quiet
        wr_exp.push_back('{32'h0000_0400, 8'hBE});
        wr_exp.push_back('{32'h0000_0401, 8'hBA});
        bus.ls_wr    = 1'b1;
        bus.ls_size  = 2'd2;
        bus.ls_addr  = 32'h0000_0400;
        bus.ls_wdata = 32'hCAFE_BABE;
        bus.ls_req   = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("rst_mid_wr", bus.mem_wr, 32'd0);
        check("rst_mid_a", bus.mem_a, 32'd0);
        check("rst_mid_done", bus.ls_done, 32'd0);
        bus.ls_req = 1'b0;
        rst_in = 1'b0;
        repeat (6) @(negedge clk_in);

        check("wr_left", wr_exp.size(), 32'd0);
        check("if_left", if_exp.size(), 32'd0);
        check("ls_left", ls_exp.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-serial RAM/IO bus (mem_a/mem_dout/mem_wr/mem_din).
- Shares the bus between two requesters:
  - the instruction-fetch unit: 32-bit reads only;
  - the load/store buffer: 1/2/4-byte reads and writes.
- Sequences multi-byte transfers one byte per cycle and absorbs the one-cycle read bubble.
- Returns assembled little-endian data plus a one-cycle done pulse to the winning requester.

Parameters:
- IO_PORT_A, 32'h30000, IO address gated by io_buffer_full
- IO_PORT_B, 32'h30004, second IO address gated by io_buffer_full

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global enable; when low all state and outputs hold
- clear  input  1  pipeline flush (misprediction)
- if_req  input  1  fetch request, held until if_done
- if_addr  input  32  fetch byte address
- if_done  output  1  one-cycle pulse, if_data valid
- if_data  output  32  fetched word
- ls_req  input  1  LSB request, held until ls_done
- ls_wr  input  1  1=store, 0=load
- ls_size  input  2  0=byte, 1=half, 2=word (3 illegal, treated as word)
- ls_addr  input  32  access byte address
- ls_wdata  input  32  store data
- ls_done  output  1  one-cycle pulse
- ls_rdata  output  32  zero-extended load data; the LSB sign-extends
- mem_din  input  8  RAM byte, valid one cycle after its address
- io_buffer_full  input  1  UART buffer full
- mem_dout  output  8  write byte
- mem_a  output  32  bus address
- mem_wr  output  1  1=write cycle

Behaviour:
- Reset values:
  - state=IDLE;
  - mem_wr=0, mem_a=0, mem_dout=0;
  - if_done=0, ls_done=0, if_data=0, ls_rdata=0.
- Synchronous reset aborts any transfer immediately; no done pulse is issued.
- States and transitions:
  - IDLE:
    - grant when ls_req or if_req is present;
    - fixed priority is LSB over IF (see Optional Feature);
    - the LSB grant is blocked while io_buffer_full=1 and ls_addr is IO_PORT_A or IO_PORT_B; IF may then be granted instead.
  - On grant:
    - latch requester, address, byte count N (1/2/4) and write data;
    - drive mem_a=addr on the grant edge;
    - go to READ or WRITE.
  - READ:
    - address byte k is on mem_a in cycle k (k=0..N-1); mem_a increments by 1 each cycle;
    - mem_din captured one cycle later into bits [8k+7:8k];
    - a byte-counter tracks issued bytes and a second counter tracks received bytes (bubble);
    - after byte N-1 is received: done pulse with data in the same cycle; return to IDLE.
    - Latency from grant edge to done: N+1 cycles.
  - WRITE:
    - mem_wr=1 with mem_dout=wdata[8k+7:8k] at addr+k for k=0..N-1;
    - done pulse in the cycle after the last byte (latency N);
    - mem_wr returns to 0 the same edge done rises.
- mem_wr=0 in IDLE and READ at all times; no spurious write cycle between back-to-back requests.
- At most one done pulse per grant. The next grant is possible in the cycle the done pulse is high (back-to-back).
- Requests that deassert before grant are dropped silently.
- clear:
  - aborts IF reads and LSB reads at once: state goes to IDLE, no done;
  - an LSB write in progress always completes and pulses ls_done (stores are committed);
  - clear in IDLE has no effect beyond suppressing a grant that cycle.
- Address arithmetic wraps modulo 2^32.
- Bits of ls_rdata above 8N are zero.
- Simultaneous if_req and ls_req with clear: clear wins and no grant is made.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - a 1-bit last-winner register; on simultaneous requests the requester not served last wins;
  - blocked IO requests do not count as served.
- Undefined: fixed LSB priority; IF may starve while the LSB streams.

Decomposition:
- Shared package/include: state encodings (IDLE, READ, WRITE), size encodings, IO_PORT address constants, requester-ID encoding.
- One natural sub-module: mem_byte_assembler, which holds the received-byte counter and the little-endian shift/placement register for READ.

Test Plan:
- IF read: if_req, if_addr=0x100, RAM bytes 11,22,33,44 -> mem_a 0x100..0x103 on consecutive cycles; if_done 5 cycles after grant; if_data=0x44332211.
- LSB store word: ls_wr=1, ls_size=2, ls_addr=0x200, ls_wdata=0xAABBCCDD -> mem_wr=1 for 4 cycles, mem_dout DD,CC,BB,AA at 0x200..0x203; ls_done next cycle.
- Contention: if_req and ls_req (load byte, 0x40) high the same cycle -> LSB served first, ls_rdata=0x000000xx; IF granted on the ls_done cycle. With MEM_ARB_ROUND_ROBIN_EN, a second contention goes to IF.
- IO gate: io_buffer_full=1 with LSB sb to 0x30000 -> no grant and mem_wr stays 0; deassert io_buffer_full -> a single write of the byte, then ls_done.
- Clear: clear mid IF read -> no if_done, IDLE the next cycle. Clear during the 2nd byte of a half store -> both bytes written, ls_done pulses.
- Reset mid-store -> mem_wr=0 the next cycle, no done, state IDLE.
